// File: rtl/dsp_ctrl_pkg.sv
// Shared constants and types for the DSP48A1 post-adder sequencer.
package dsp_ctrl_pkg;

    localparam logic [1:0] X_SEL_ZERO = 2'b00;
    localparam logic [1:0] X_SEL_PROD = 2'b01;

    localparam logic [1:0] Z_SEL_ZERO = 2'b00;
    localparam logic [1:0] Z_SEL_PFB  = 2'b01;
    localparam logic [1:0] Z_SEL_C    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic sub;
        logic init_c;
        logic rnd;
    } job_cfg_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Job, sample and result handshakes between a sample source and the sequencer.
interface dsp_mac_sequencer_if #(
    parameter int unsigned LEN_W = 8
);
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic             job_sub;
    logic             job_init_c;
    logic             job_rnd;
    logic             sample_valid;
    logic             sample_ready;
    logic             result_valid;
    logic             result_ready;

    modport master (
        output job_valid, job_len, job_sub, job_init_c, job_rnd,
        output sample_valid, result_ready,
        input  job_ready, sample_ready, result_valid
    );

    modport slave (
        input  job_valid, job_len, job_sub, job_init_c, job_rnd,
        input  sample_valid, result_ready,
        output job_ready, sample_ready, result_valid
    );
endinterface

// File: rtl/dsp_seq_counter.sv
// Loadable down-counter with zero/one flags; saturates at zero.
module dsp_seq_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         is_zero,
    output logic         is_one
);
    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - W'(1);
        end
    end

    assign is_zero = (value == '0);
    assign is_one  = (value == W'(1));
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences the DSP48A1 post-adder through N-sample multiply-accumulate jobs.
module dsp_mac_sequencer
    import dsp_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned P_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 abort,
    dsp_mac_sequencer_if.slave   bus,
    output logic [1:0]           mux_X_sel,
    output logic [1:0]           mux_Z_sel,
    output logic                 add_sub_sel,
    output logic                 cin,
    output logic                 ce_carry,
    output logic                 ce_out,
    output logic                 rst_carry_o,
    output logic                 rst_out_o
);
    localparam int unsigned DLY_W = (P_LAT > 1) ? $clog2(P_LAT) : 1;

    seq_state_e state, state_nxt;
    job_cfg_t   cfg;
    logic       first;
    logic       abort_pend;
    logic       job_take, accept, drain_load;
    logic       cnt_zero, cnt_one, drain_zero, drain_one;

    assign job_take   = (state == ST_IDLE) && bus.job_valid;
    assign accept     = (state == ST_ACCUM) && bus.sample_valid;
    assign drain_load = (state_nxt == ST_DRAIN) && (state != ST_DRAIN);

    dsp_seq_counter #(.W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (job_take),
        .load_val (LEN_W'(bus.job_len)),
        .dec      (accept),
        .is_zero  (cnt_zero),
        .is_one   (cnt_one)
    );

    dsp_seq_counter #(.W(DLY_W)) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (drain_load),
        .load_val (DLY_W'(P_LAT - 1)),
        .dec      (state == ST_DRAIN),
        .is_zero  (drain_zero),
        .is_one   (drain_one)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Job fields, first-sample flag and the abort-return marker for CLEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg        <= '0;
            first      <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (job_take) begin
                cfg   <= '{sub: bus.job_sub, init_c: bus.job_init_c, rnd: bus.job_rnd};
                first <= 1'b1;
            end else if (accept) begin
                first <= 1'b0;
            end
            if (abort && (state != ST_IDLE)) abort_pend <= 1'b1;
            else if (state == ST_CLEAR)      abort_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt        = state;
        bus.job_ready    = 1'b0;
        bus.sample_ready = 1'b0;
        bus.result_valid = 1'b0;
        mux_X_sel        = X_SEL_ZERO;
        mux_Z_sel        = Z_SEL_ZERO;
        add_sub_sel      = 1'b0;
        cin              = 1'b0;
        ce_carry         = 1'b0;
        ce_out           = 1'b0;
        rst_carry_o      = 1'b0;
        rst_out_o        = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.job_ready = 1'b1;
                if (bus.job_valid) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                rst_out_o   = 1'b1;
                rst_carry_o = 1'b1;
                if (abort_pend)     state_nxt = ST_IDLE;
                else if (!cnt_zero) state_nxt = ST_ACCUM;
                else                state_nxt = (P_LAT == 1) ? ST_DONE : ST_DRAIN;
            end
            ST_ACCUM: begin
                bus.sample_ready = 1'b1;
                mux_X_sel        = X_SEL_PROD;
                add_sub_sel      = cfg.sub;
                mux_Z_sel        = first ? (cfg.init_c ? Z_SEL_C : Z_SEL_ZERO) : Z_SEL_PFB;
                cin              = first & cfg.rnd;
                ce_out           = bus.sample_valid;
                ce_carry         = bus.sample_valid;
                if (accept && cnt_one) state_nxt = (P_LAT == 1) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_one || drain_zero) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.result_valid = 1'b1;
                if (bus.result_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything outside IDLE, including result_ready in DONE.
        if (abort && (state != ST_IDLE)) state_nxt = ST_CLEAR;
    end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench: DSP post-adder model driven by the sequencer controls.
module tb_dsp_mac_sequencer;
    import dsp_ctrl_pkg::*;

    localparam int unsigned LEN_W = 8;
    localparam int NVEC = 12;

    typedef struct {
        int               len;
        logic             sub;
        logic             init_c;
        logic             rnd;
        logic [47:0]      c;
        logic [7:0][15:0] prod;
        int               gap;
        int               hold;
        logic [47:0]      exp_p;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, abort;
    logic [1:0] mux_X_sel, mux_Z_sel;
    logic add_sub_sel, cin, ce_carry, ce_out, rst_carry_o, rst_out_o;
    logic [1:0] mux_X_sel3, mux_Z_sel3;
    logic add_sub_sel3, cin3, ce_carry3, ce_out3, rst_carry_o3, rst_out_o3;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();
    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus3 ();

    dsp_mac_sequencer #(.LEN_W(LEN_W), .P_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus),
        .mux_X_sel(mux_X_sel), .mux_Z_sel(mux_Z_sel), .add_sub_sel(add_sub_sel),
        .cin(cin), .ce_carry(ce_carry), .ce_out(ce_out),
        .rst_carry_o(rst_carry_o), .rst_out_o(rst_out_o)
    );

    dsp_mac_sequencer #(.LEN_W(LEN_W), .P_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .abort(1'b0), .bus(bus3),
        .mux_X_sel(mux_X_sel3), .mux_Z_sel(mux_Z_sel3), .add_sub_sel(add_sub_sel3),
        .cin(cin3), .ce_carry(ce_carry3), .ce_out(ce_out3),
        .rst_carry_o(rst_carry_o3), .rst_out_o(rst_out_o3)
    );

    // Post-adder and P register of the slice, single-cycle latency.
    logic [15:0] prod;
    logic [47:0] c_val, p_reg, dp_x, dp_z;
    always_comb begin
        dp_x = (mux_X_sel == X_SEL_PROD) ? 48'(prod) : 48'd0;
        case (mux_Z_sel)
            Z_SEL_PFB: dp_z = p_reg;
            Z_SEL_C:   dp_z = c_val;
            default:   dp_z = 48'd0;
        endcase
    end
    always @(posedge clk) begin
        if (rst_out_o)   p_reg <= 48'd0;
        else if (ce_out) p_reg <= add_sub_sel ? dp_z - (dp_x + 48'(cin)) : dp_z + dp_x + 48'(cin);
    end

    int checks = 0;
    int errors = 0;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [12:0] ctl_vec();
        return {bus.job_ready, bus.sample_ready, bus.result_valid, mux_X_sel, mux_Z_sel,
                add_sub_sel, cin, ce_carry, ce_out, rst_carry_o, rst_out_o};
    endfunction

    // Expected final P from the job definition alone.
    function automatic logic [47:0] ref_mac(input vec_t v);
        logic [47:0] base, sum;
        if (v.len == 0) return 48'd0;
        base = v.init_c ? v.c : 48'd0;
        sum  = 48'(v.rnd);
        for (int i = 0; i < v.len; i++) sum = sum + 48'(v.prod[i]);
        return v.sub ? base - sum : base + sum;
    endfunction

    task automatic run_job(input vec_t v, input string tag);
        int idx, gapc, wc, k;
        logic [47:0] p_hold;
        logic [1:0] zexp;
        bit saw_sr;
        wc = 0;
        while (!bus.job_ready && wc < 50) begin @(negedge clk); wc++; end
        chk({tag, "_job_ready"}, 64'(bus.job_ready), 64'd1);
        bus.job_valid = 1'b1; bus.job_len = LEN_W'(v.len);
        bus.job_sub = v.sub; bus.job_init_c = v.init_c; bus.job_rnd = v.rnd;
        c_val = v.c;
        @(negedge clk);
        bus.job_valid = 1'b0;
        chk({tag, "_clear_rst"}, 64'({rst_out_o, rst_carry_o, ce_out, bus.sample_ready}), 64'b1100);
        idx = 0; gapc = 0; wc = 0;
        while (idx < v.len && wc < 200) begin
            bus.sample_valid = (gapc == 0);
            prod = v.prod[idx];
            #1;
            if (bus.sample_valid && bus.sample_ready) begin
                zexp = (idx == 0) ? (v.init_c ? Z_SEL_C : Z_SEL_ZERO) : Z_SEL_PFB;
                chk({tag, "_acc_ctl"}, 64'({mux_X_sel, mux_Z_sel, add_sub_sel, cin, ce_out, ce_carry}),
                    64'({X_SEL_PROD, zexp, v.sub, (idx == 0) & v.rnd, 1'b1, 1'b1}));
                idx++;
                gapc = v.gap;
            end else begin
                if (bus.sample_ready) chk({tag, "_idle_ce"}, 64'({ce_out, ce_carry}), 64'd0);
                if (gapc > 0) gapc--;
            end
            @(negedge clk);
            wc++;
        end
        bus.sample_valid = 1'b0;
        if (idx < v.len) chk({tag, "_sample_timeout"}, 64'(idx), 64'(v.len));
        k = 0; saw_sr = 1'b0;
        while (!bus.result_valid && k < 20) begin
            if (bus.sample_ready) saw_sr = 1'b1;
            @(negedge clk); k++;
        end
        chk({tag, "_done_lat"}, 64'(k), (v.len == 0) ? 64'd1 : 64'd0);
        if (v.len == 0) chk({tag, "_no_sample_ready"}, 64'(saw_sr), 64'd0);
        chk({tag, "_result_valid"}, 64'(bus.result_valid), 64'd1);
        chk({tag, "_p"}, 64'(p_reg), 64'(v.exp_p));
        p_hold = p_reg;
        bus.result_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold"}, 64'({bus.result_valid, ce_out, p_reg}), 64'({1'b1, 1'b0, p_hold}));
        end
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
        chk({tag, "_back_idle"}, 64'({bus.job_ready, bus.result_valid}), 64'b10);
    endtask

    initial begin
        vec_t v;
        int k;
        rst_n = 1'b0; abort = 1'b0; prod = '0; c_val = '0;
        bus.job_valid = 0; bus.job_len = '0; bus.job_sub = 0; bus.job_init_c = 0; bus.job_rnd = 0;
        bus.sample_valid = 0; bus.result_ready = 0;
        bus3.job_valid = 0; bus3.job_len = '0; bus3.job_sub = 0; bus3.job_init_c = 0; bus3.job_rnd = 0;
        bus3.sample_valid = 0; bus3.result_ready = 0;

        tbl[0] = '{len:3, sub:1'b0, init_c:1'b0, rnd:1'b0, c:48'd0,
                   prod:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 16'd7, 16'd5},
                   gap:0, hold:0, exp_p:48'd21};
        tbl[1] = '{len:2, sub:1'b1, init_c:1'b1, rnd:1'b1, c:48'd100,
                   prod:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd20, 16'd10},
                   gap:0, hold:0, exp_p:48'd69};
        tbl[2] = '{len:4, sub:1'b0, init_c:1'b0, rnd:1'b0, c:48'd0,
                   prod:{16'd0, 16'd0, 16'd0, 16'd0, 16'd4, 16'd3, 16'd2, 16'd1},
                   gap:1, hold:5, exp_p:48'd10};
        tbl[3] = '{len:0, sub:1'b0, init_c:1'b1, rnd:1'b1, c:48'd55,
                   prod:'0, gap:0, hold:1, exp_p:48'd0};
        tbl[4] = '{len:2, sub:1'b1, init_c:1'b0, rnd:1'b0, c:48'd0,
                   prod:{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'd2},
                   gap:0, hold:0, exp_p:48'hFFFF_FFFF_FFFB};
        for (int i = 5; i < NVEC; i++) begin
            v.len = int'($urandom_range(0, 8));
            v.sub = 1'($urandom); v.init_c = 1'($urandom); v.rnd = 1'($urandom);
            v.c = 48'({$urandom, $urandom});
            for (int j = 0; j < 8; j++) v.prod[j] = 16'($urandom);
            v.gap = int'($urandom_range(0, 2));
            v.hold = int'($urandom_range(0, 3));
            v.exp_p = ref_mac(v);
            tbl[i] = v;
        end

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(ctl_vec()), 64'h1000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", 64'(ctl_vec()), 64'h1000);

        for (int i = 0; i < NVEC; i++) run_job(tbl[i], $sformatf("vec%0d", i));

        // Abort after two of five samples.
        bus.job_valid = 1; bus.job_len = LEN_W'(5); bus.job_sub = 0; bus.job_init_c = 0; bus.job_rnd = 0;
        @(negedge clk); bus.job_valid = 0;
        @(negedge clk); bus.sample_valid = 1; prod = 16'd4;
        @(negedge clk);
        @(negedge clk); bus.sample_valid = 0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_clear", 64'({rst_out_o, rst_carry_o, bus.result_valid}), 64'b110);
        @(negedge clk);
        chk("abort_idle", 64'(ctl_vec()), 64'h1000);
        v = tbl[0]; v.len = 1; v.prod = '0; v.prod[0] = 16'd3; v.exp_p = 48'd3; v.gap = 0; v.hold = 0;
        run_job(v, "post_abort");

        // Synchronous reset in the middle of ACCUM.
        bus.job_valid = 1; bus.job_len = LEN_W'(4); bus.job_init_c = 1;
        @(negedge clk); bus.job_valid = 0;
        @(negedge clk); bus.sample_valid = 1; prod = 16'd7;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; bus.sample_valid = 0;
        chk("reset_mid_accum", 64'(ctl_vec()), 64'h1000);

        // P_LAT=3: DONE two cycles after the last accept, controls quiet while draining.
        bus3.job_valid = 1; bus3.job_len = LEN_W'(2);
        @(negedge clk); bus3.job_valid = 0;
        @(negedge clk); bus3.sample_valid = 1;
        #1 chk("plat3_sr0", 64'(bus3.sample_ready), 64'd1);
        @(negedge clk);
        #1 chk("plat3_sr1", 64'(bus3.sample_ready), 64'd1);
        @(negedge clk); bus3.sample_valid = 0;
        k = 1;
        while (!bus3.result_valid && k < 20) begin
            chk("plat3_drain_ctl", 64'({mux_X_sel3, mux_Z_sel3, ce_out3, ce_carry3}), 64'd0);
            @(negedge clk); k++;
        end
        chk("plat3_done_latency", 64'(k - 1), 64'd2);
        bus3.result_ready = 1;
        @(negedge clk); bus3.result_ready = 0;
        chk("plat3_back_idle", 64'({bus3.job_ready, bus3.result_valid}), 64'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
